// File: rtl/tdm_demux4.sv
// Receive side of a 4-channel TDM link: slot tracking from frame sync, shadow capture, framed outputs.
// Optional parity slot enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             par_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif
  localparam logic [2:0] LAST = 3'(L - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       slot_reg, slot_next;
  logic [WIDTH-1:0] sh_reg  [4];
  logic [WIDTH-1:0] sh_next [4];
  logic [WIDTH-1:0] out_reg [4];
  logic [WIDTH-1:0] out_next[4];
  logic             fv_reg, fv_next;
  logic             se_reg, se_next;
  logic             pe_reg, pe_next;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    for (int i = 0; i < 4; i++) begin
      sh_next[i]  = sh_reg[i];
      out_next[i] = out_reg[i];
    end
    fv_next = 1'b0;
    se_next = 1'b0;
    pe_next = 1'b0;
    if (en) begin
      if (sync) begin
        // A sync anywhere but slot 0 of a running frame aborts the partial frame.
        se_next    = (state_reg == RUN) && (slot_reg != 3'd0);
        sh_next[0] = din;
        slot_next  = 3'd1;
        state_next = RUN;
      end else if (state_reg == RUN) begin
        if (slot_reg == 3'd0) begin
          se_next    = 1'b1;
          state_next = HUNT;
        end else if (slot_reg == LAST) begin
          for (int i = 0; i < 4; i++) out_next[i] = sh_reg[i];
`ifdef TDM_DEMUX_PARITY_EN
          pe_next = (din != (sh_reg[0] ^ sh_reg[1] ^ sh_reg[2] ^ sh_reg[3]));
`else
          // Without parity the last data slot bypasses its shadow register.
          out_next[3] = din;
`endif
          fv_next   = 1'b1;
          slot_next = 3'd0;
        end else begin
          sh_next[slot_reg[1:0]] = din;
          slot_next              = slot_reg + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= HUNT;
      slot_reg  <= 3'd0;
      fv_reg    <= 1'b0;
      se_reg    <= 1'b0;
      pe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      fv_reg    <= fv_next;
      se_reg    <= se_next;
      pe_reg    <= pe_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sh_reg[gi]  <= '0;
          out_reg[gi] <= '0;
        end else begin
          sh_reg[gi]  <= sh_next[gi];
          out_reg[gi] <= out_next[gi];
        end
      end
    end
  endgenerate

  assign out0        = out_reg[0];
  assign out1        = out_reg[1];
  assign out2        = out_reg[2];
  assign out3        = out_reg[3];
  assign frame_valid = fv_reg;
  assign sync_err    = se_reg;
  assign par_err     = pe_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 at WIDTH = 4; covers the parity slot when TDM_DEMUX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_tdm_demux4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             sync;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             frame_valid, sync_err, par_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .din(din), .en(en), .sync(sync),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then settle just after the rising edge.
  task automatic step(input logic e, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    $display("beat en=%0b sync=%0b din=%h -> out=%h,%h,%h,%h fv=%0b se=%0b pe=%0b",
             e, s, d, out0, out1, out2, out3, frame_valid, sync_err, par_err);
  endtask

  // Parity beat when the parity slot exists; nothing otherwise.
  task automatic tail(input logic [WIDTH-1:0] p);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, p);
`else
    p = p;
`endif
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    check({tag, ".out0"}, 32'(out0), 32'(a));
    check({tag, ".out1"}, 32'(out1), 32'(b));
    check({tag, ".out2"}, 32'(out2), 32'(c));
    check({tag, ".out3"}, 32'(out3), 32'(d));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    check("reset.fv", 32'(frame_valid), 32'd0);
    check("reset.se", 32'(sync_err), 32'd0);
    check("reset.pe", 32'(par_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Clean frame A,B,C,D
    step(1'b1, 1'b1, 4'hA);
    check("clean.fv_early", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'hC);
    step(1'b1, 1'b0, 4'hD);
    tail(4'hA ^ 4'hB ^ 4'hC ^ 4'hD);
    check("clean.fv", 32'(frame_valid), 32'd1);
    check("clean.se", 32'(sync_err), 32'd0);
    check("clean.pe", 32'(par_err), 32'd0);
    check_outs("clean", 4'hA, 4'hB, 4'hC, 4'hD);
    step(1'b0, 1'b0, 4'h0);
    check("clean.fv_clear", 32'(frame_valid), 32'd0);

    // Frame 3,9,6,C with three disabled cycles between beats; sync and din toggle in gaps
    step(1'b1, 1'b1, 4'h3);
    for (int g = 0; g < 3; g++) step(1'b0, g[0], 4'(g + 5));
    check("gap.hold0", 32'(out0), 32'hA);
    step(1'b1, 1'b0, 4'h9);
    for (int g = 0; g < 3; g++) step(1'b0, ~g[0], 4'(g + 1));
    check("gap.fv_mid", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'h6);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 4'hF);
    check("gap.se_mid", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, 4'hC);
    tail(4'h3 ^ 4'h9 ^ 4'h6 ^ 4'hC);
    check("gap.fv", 32'(frame_valid), 32'd1);
    check_outs("gap", 4'h3, 4'h9, 4'h6, 4'hC);
    step(1'b0, 1'b0, 4'h0);
    check("gap.fv_clear", 32'(frame_valid), 32'd0);

    // Early sync: partial frame 1,2 is dropped
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b1, 4'h5);
    check("early.se", 32'(sync_err), 32'd1);
    check("early.fv", 32'(frame_valid), 32'd0);
    check_outs("early.hold", 4'h3, 4'h9, 4'h6, 4'hC);
    step(1'b1, 1'b0, 4'h6);
    check("early.se_clear", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h8);
    tail(4'h5 ^ 4'h6 ^ 4'h7 ^ 4'h8);
    check("early.fv_done", 32'(frame_valid), 32'd1);
    check("early.se_done", 32'(sync_err), 32'd0);
    check_outs("early", 4'h5, 4'h6, 4'h7, 4'h8);

    // Missing sync after a good frame
    step(1'b1, 1'b0, 4'hF);
    check("miss.se", 32'(sync_err), 32'd1);
    check("miss.fv", 32'(frame_valid), 32'd0);
    for (int g = 0; g < 5; g++) step(1'b1, 1'b0, 4'(g + 9));
    check("miss.se_hunt", 32'(sync_err), 32'd0);
    check("miss.fv_hunt", 32'(frame_valid), 32'd0);
    check_outs("miss.hold", 4'h5, 4'h6, 4'h7, 4'h8);
    step(1'b1, 1'b1, 4'hE);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'h7);
    tail(4'hE ^ 4'hD ^ 4'hB ^ 4'h7);
    check("miss.fv_new", 32'(frame_valid), 32'd1);
    check_outs("miss.new", 4'hE, 4'hD, 4'hB, 4'h7);

    // Asynchronous reset between edges, two slots into a frame
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    #2 reset = 1'b1;
    #1;
    check_outs("areset", 4'h0, 4'h0, 4'h0, 4'h0);
    check("areset.fv", 32'(frame_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 4'h3);
    check("areset.hunt_fv", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b1, 4'h4);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'h7);
    tail(4'h4 ^ 4'h5 ^ 4'h6 ^ 4'h7);
    check("areset.fv_new", 32'(frame_valid), 32'd1);
    check("areset.pe_new", 32'(par_err), 32'd0);
    check_outs("areset.new", 4'h4, 4'h5, 4'h6, 4'h7);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity good then parity bad
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h8);
    check("par.fv_early", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b0, 4'hF);
    check("par_ok.fv", 32'(frame_valid), 32'd1);
    check("par_ok.pe", 32'(par_err), 32'd0);
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h8);
    step(1'b1, 1'b0, 4'hE);
    check("par_bad.fv", 32'(frame_valid), 32'd1);
    check("par_bad.pe", 32'(par_err), 32'd1);
    check_outs("par_bad", 4'h1, 4'h2, 4'h4, 4'h8);
    step(1'b0, 1'b0, 4'h0);
    check("par_bad.pe_clear", 32'(par_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
